// File: rtl/regfile_port_sequencer_if.sv
// Request/response handshake and register-file port bundle for regfile_port_sequencer.
// slave is the sequencer's view; master is the client plus register file side.
interface regfile_port_sequencer_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   src_a;
  logic [ID_W-1:0]   src_b;
  logic [ID_W-1:0]   dst_e;
  logic [ID_W-1:0]   dst_m;
  logic [DATA_W-1:0] val_e;
  logic [DATA_W-1:0] val_m;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  logic [ID_W-1:0]   rf_reg_id_read;
  logic              rf_read_en;
  logic [DATA_W-1:0] rf_value_read;
  logic [ID_W-1:0]   rf_reg_id_write;
  logic [DATA_W-1:0] rf_value_write;
  logic              rf_write_en;

  modport slave (
    input  req_valid, src_a, src_b, dst_e, dst_m, val_e, val_m, rsp_ready, rf_value_read,
    output req_ready, rsp_valid, val_a, val_b, rf_reg_id_read, rf_read_en,
           rf_reg_id_write, rf_value_write, rf_write_en
  );

  modport master (
    output req_valid, src_a, src_b, dst_e, dst_m, val_e, val_m, rsp_ready, rf_value_read,
    input  req_ready, rsp_valid, val_a, val_b, rf_reg_id_read, rf_read_en,
           rf_reg_id_write, rf_value_write, rf_write_en
  );
endinterface

// File: rtl/regfile_port_sequencer.sv
// Serialises one decode/writeback request onto a single-read/single-write register file:
// read A, read B, write E, write M, then returns val_a/val_b over a valid/ready response.
module regfile_port_sequencer #(
  parameter int unsigned     DATA_W = 64,
  parameter int unsigned     ID_W   = 4,
  parameter logic [ID_W-1:0] RNONE  = '1,
  parameter int unsigned     RD_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_port_sequencer_if.slave  bus_io
);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StWrE, StWrM, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q;
  logic [ID_W-1:0]   src_a_q, src_b_q, dst_e_q, dst_m_q;
  logic [DATA_W-1:0] val_e_q, val_m_q;
  logic              req_ready_q, rsp_valid_q, rd_en_q, wr_en_q;
  logic [DATA_W-1:0] val_a_q, val_b_q, wr_data_q;
  logic [ID_W-1:0]   rd_id_q, wr_id_q;

  logic              accept, rd_last;
  logic [ID_W-1:0]   a_eff, b_eff, e_eff, m_eff;
  logic [DATA_W-1:0] ve_eff, vm_eff;

  // Skip chain: the first phase whose id is not RNONE is entered directly.
  function automatic state_e from_wr_m(logic [ID_W-1:0] m);
    return (m != RNONE) ? StWrM : StResp;
  endfunction

  function automatic state_e from_wr_e(logic [ID_W-1:0] e, logic [ID_W-1:0] m);
    return (e != RNONE) ? StWrE : from_wr_m(m);
  endfunction

  function automatic state_e from_rd_b(logic [ID_W-1:0] b, logic [ID_W-1:0] e,
                                       logic [ID_W-1:0] m);
    return (b != RNONE) ? StRdB : from_wr_e(e, m);
  endfunction

  function automatic state_e from_rd_a(logic [ID_W-1:0] a, logic [ID_W-1:0] b,
                                       logic [ID_W-1:0] e, logic [ID_W-1:0] m);
    return (a != RNONE) ? StRdA : from_rd_b(b, e, m);
  endfunction

  always_comb begin
    accept  = (state_q == StIdle) && bus_io.req_valid;
    rd_last = (cnt_q == 2'(RD_LAT));
    // On the accept edge the request fields are not yet latched, so use them live.
    a_eff   = accept ? bus_io.src_a : src_a_q;
    b_eff   = accept ? bus_io.src_b : src_b_q;
    e_eff   = accept ? bus_io.dst_e : dst_e_q;
    m_eff   = accept ? bus_io.dst_m : dst_m_q;
    ve_eff  = accept ? bus_io.val_e : val_e_q;
    vm_eff  = accept ? bus_io.val_m : val_m_q;
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus_io.req_valid) state_d = from_rd_a(a_eff, b_eff, e_eff, m_eff);
      StRdA:   if (rd_last) state_d = from_rd_b(b_eff, e_eff, m_eff);
      StRdB:   if (rd_last) state_d = from_wr_e(e_eff, m_eff);
      StWrE:   state_d = from_wr_m(m_eff);
      StWrM:   state_d = StResp;
      StResp:  if (bus_io.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      dst_e_q     <= '0;
      dst_m_q     <= '0;
      val_e_q     <= '0;
      val_m_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      rd_en_q     <= 1'b0;
      rd_id_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_id_q     <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= ((state_d == state_q) && ((state_q == StRdA) || (state_q == StRdB))) ?
                 cnt_q + 2'd1 : 2'd0;
      if (accept) begin
        src_a_q <= bus_io.src_a;
        src_b_q <= bus_io.src_b;
        dst_e_q <= bus_io.dst_e;
        dst_m_q <= bus_io.dst_m;
        val_e_q <= bus_io.val_e;
        val_m_q <= bus_io.val_m;
        if (bus_io.src_a == RNONE) val_a_q <= '0;
        if (bus_io.src_b == RNONE) val_b_q <= '0;
      end
      if ((state_q == StRdA) && rd_last) val_a_q <= bus_io.rf_value_read;
      if ((state_q == StRdB) && rd_last) val_b_q <= bus_io.rf_value_read;
      req_ready_q <= (state_d == StIdle);
      rsp_valid_q <= (state_d == StResp);
      rd_en_q     <= (state_d == StRdA) || (state_d == StRdB);
      rd_id_q     <= (state_d == StRdA) ? a_eff : (state_d == StRdB) ? b_eff : '0;
      wr_en_q     <= (state_d == StWrE) || (state_d == StWrM);
      wr_id_q     <= (state_d == StWrE) ? e_eff : (state_d == StWrM) ? m_eff : '0;
      wr_data_q   <= (state_d == StWrE) ? ve_eff : (state_d == StWrM) ? vm_eff : '0;
    end
  end

  assign bus_io.req_ready       = req_ready_q;
  assign bus_io.rsp_valid       = rsp_valid_q;
  assign bus_io.val_a           = val_a_q;
  assign bus_io.val_b           = val_b_q;
  assign bus_io.rf_read_en      = rd_en_q;
  assign bus_io.rf_reg_id_read  = rd_id_q;
  assign bus_io.rf_write_en     = wr_en_q;
  assign bus_io.rf_reg_id_write = wr_id_q;
  assign bus_io.rf_value_write  = wr_data_q;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench: RD_LAT=0 instance for the main sequences, RD_LAT=2 instance for
// stretched reads and reset during a write. Register file model preloads r[i] = i*0x11.
module tb_regfile_port_sequencer;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;

  bit   clk = 1'b0;
  logic rst;
  logic mdl_init;
  int   n_vec = 0;
  int   n_err = 0;

  regfile_port_sequencer_if #(.DATA_W(DW), .ID_W(IW)) b0 ();
  regfile_port_sequencer_if #(.DATA_W(DW), .ID_W(IW)) b1 ();

  regfile_port_sequencer #(.DATA_W(DW), .ID_W(IW), .RNONE(4'hF), .RD_LAT(0)) dut0 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (b0)
  );

  regfile_port_sequencer #(.DATA_W(DW), .ID_W(IW), .RNONE(4'hF), .RD_LAT(2)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (b1)
  );

  logic [DW-1:0] rf0 [16];
  logic [DW-1:0] rf1 [16];
  int rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
  bit ovl0 = 1'b0, ovl1 = 1'b0;

  assign b0.rf_value_read = rf0[b0.rf_reg_id_read];
  assign b1.rf_value_read = rf1[b1.rf_reg_id_read];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mdl_init) begin
      for (int i = 0; i < 16; i++) begin
        rf0[i] <= 64'(i * 17);
        rf1[i] <= 64'(i * 17);
      end
    end else begin
      if (b0.rf_write_en) rf0[b0.rf_reg_id_write] <= b0.rf_value_write;
      if (b1.rf_write_en) rf1[b1.rf_reg_id_write] <= b1.rf_value_write;
    end
    if (b0.rf_read_en) rd0 <= rd0 + 1;
    if (b0.rf_write_en) wr0 <= wr0 + 1;
    if (b1.rf_read_en) rd1 <= rd1 + 1;
    if (b1.rf_write_en) wr1 <= wr1 + 1;
    if (b0.rf_read_en && b0.rf_write_en) ovl0 <= 1'b1;
    if (b1.rf_read_en && b1.rf_write_en) ovl1 <= 1'b1;
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [3:0] a, input logic [3:0] b, input logic [3:0] e,
                       input logic [63:0] ve, input logic [3:0] m, input logic [63:0] vm);
    b0.src_a = a; b0.src_b = b; b0.dst_e = e; b0.dst_m = m; b0.val_e = ve; b0.val_m = vm;
    b0.req_valid = 1'b1;
    check("accept_ready", b0.req_ready, 1);
    tick();
    // Junk after the accept edge must be ignored.
    b0.req_valid = 1'b0;
    b0.src_a = 4'h1; b0.src_b = 4'h1; b0.dst_e = 4'h1; b0.dst_m = 4'h1;
    b0.val_e = '1;   b0.val_m = '1;
  endtask

  task automatic wait_rsp0(output int lat);
    lat = 0;
    while (!b0.rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!b0.rsp_valid) check("rsp_timeout", b0.rsp_valid, 1);
  endtask

  task automatic ack0();
    b0.rsp_ready = 1'b1;
    tick();
    b0.rsp_ready = 1'b0;
    check("idle_ready", b0.req_ready, 1);
    check("idle_rsp_low", b0.rsp_valid, 0);
  endtask

  int lat;
  int r_snap, w_snap;

  initial begin
    rst = 1'b0;
    mdl_init = 1'b1;
    b0.req_valid = 0; b0.rsp_ready = 0; b0.src_a = 0; b0.src_b = 0; b0.dst_e = 0;
    b0.dst_m = 0; b0.val_e = 0; b0.val_m = 0;
    b1.req_valid = 0; b1.rsp_ready = 0; b1.src_a = 0; b1.src_b = 0; b1.dst_e = 0;
    b1.dst_m = 0; b1.val_e = 0; b1.val_m = 0;

    // Test 1: asynchronous reset mid-cycle.
    #2 rst = 1'b1;
    #1;
    check("rst_req_ready", b0.req_ready, 1);
    check("rst_rsp_valid", b0.rsp_valid, 0);
    check("rst_rd_en", b0.rf_read_en, 0);
    check("rst_wr_en", b0.rf_write_en, 0);
    check("rst_val_a", b0.val_a, 0);
    check("rst_wr_data", b0.rf_value_write, 0);
    check("rst1_wr_en", b1.rf_write_en, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    mdl_init = 1'b0;
    tick();
    check("post_rst_ready", b0.req_ready, 1);

    // Test 2: full sequence, RD_LAT=0.
    send0(4'd3, 4'd4, 4'd5, 64'hAA, 4'd6, 64'hBB);
    check("t2_rda_en", b0.rf_read_en, 1);
    check("t2_rda_id", b0.rf_reg_id_read, 3);
    check("t2_rda_wr_en", b0.rf_write_en, 0);
    check("t2_busy", b0.req_ready, 0);
    tick();
    check("t2_rdb_id", b0.rf_reg_id_read, 4);
    tick();
    check("t2_wre_en", b0.rf_write_en, 1);
    check("t2_wre_rd_en", b0.rf_read_en, 0);
    check("t2_wre_id", b0.rf_reg_id_write, 5);
    check("t2_wre_data", b0.rf_value_write, 64'hAA);
    tick();
    check("t2_wrm_id", b0.rf_reg_id_write, 6);
    check("t2_wrm_data", b0.rf_value_write, 64'hBB);
    tick();
    check("t2_rsp_valid", b0.rsp_valid, 1);
    check("t2_rsp_wr_en", b0.rf_write_en, 0);
    check("t2_val_a", b0.val_a, 64'h33);
    check("t2_val_b", b0.val_b, 64'h44);
    ack0();
    check("t2_r5", rf0[5], 64'hAA);
    check("t2_r6", rf0[6], 64'hBB);

    // Test 3: everything skipped.
    r_snap = rd0; w_snap = wr0;
    send0(4'hF, 4'hF, 4'hF, 64'h12, 4'hF, 64'h34);
    wait_rsp0(lat);
    check("t3_latency", 64'(lat), 0);
    check("t3_val_a", b0.val_a, 0);
    check("t3_val_b", b0.val_b, 0);
    ack0();
    check("t3_no_reads", 64'(rd0 - r_snap), 0);
    check("t3_no_writes", 64'(wr0 - w_snap), 0);

    // Test 4: read and both writes to r2, B skipped.
    send0(4'd2, 4'hF, 4'd2, 64'h1, 4'd2, 64'h2);
    check("t4_rda_id", b0.rf_reg_id_read, 2);
    tick();
    check("t4_wre_en", b0.rf_write_en, 1);
    check("t4_wre_data", b0.rf_value_write, 64'h1);
    tick();
    check("t4_wrm_data", b0.rf_value_write, 64'h2);
    tick();
    check("t4_rsp_valid", b0.rsp_valid, 1);
    check("t4_val_a", b0.val_a, 64'h22);
    ack0();
    check("t4_r2", rf0[2], 64'h2);

    // Test 5: response held under back-pressure, new requests refused.
    r_snap = rd0;
    send0(4'd6, 4'd5, 4'hF, 64'h0, 4'hF, 64'h0);
    wait_rsp0(lat);
    check("t5_latency", 64'(lat), 2);
    b0.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_valid", b0.rsp_valid, 1);
      check("t5_hold_val_a", b0.val_a, 64'hBB);
      check("t5_hold_val_b", b0.val_b, 64'hAA);
      check("t5_hold_busy", b0.req_ready, 0);
    end
    b0.req_valid = 1'b0;
    ack0();
    check("t5_reads", 64'(rd0 - r_snap), 2);

    // Test 6: RD_LAT=2, reset during WR_E.
    r_snap = rd1; w_snap = wr1;
    b1.src_a = 4'd3; b1.src_b = 4'd4; b1.dst_e = 4'd5; b1.dst_m = 4'd6;
    b1.val_e = 64'h55AA; b1.val_m = 64'h66BB;
    b1.req_valid = 1'b1;
    tick();
    b1.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_rda_en", b1.rf_read_en, 1);
      check("t6_rda_id", b1.rf_reg_id_read, 3);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("t6_rdb_id", b1.rf_reg_id_read, 4);
      tick();
    end
    check("t6_val_a", b1.val_a, 64'h33);
    check("t6_val_b", b1.val_b, 64'h44);
    check("t6_wre_en", b1.rf_write_en, 1);
    check("t6_wre_id", b1.rf_reg_id_write, 5);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_wr_en", b1.rf_write_en, 0);
    check("t6_rst_wr_id", b1.rf_reg_id_write, 0);
    check("t6_rst_ready", b1.req_ready, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("t6_reads", 64'(rd1 - r_snap), 6);
    check("t6_no_writes", 64'(wr1 - w_snap), 0);
    check("t6_r5", rf1[5], 64'h55);
    check("t6_r6", rf1[6], 64'h66);
    check("t6_val_a_rst", b1.val_a, 0);
    check("t6_idle", b1.rsp_valid, 0);

    check("overlap0", 64'(ovl0), 0);
    check("overlap1", 64'(ovl1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
